// File: rtl/mem_arb_pkg.sv
// Shared constants for the data memory arbiter: FSM encodings and port ids.
package mem_arb_pkg;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Requester port identifiers
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin pick: a lone request wins; on a tie the port that was
// not granted last time wins.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       valid_c,
  output logic       winner_c
);

  // Winner selection from request levels and previous grant
  always_comb begin
    valid_c  = |req;
    winner_c = PORT_CPU;
    if (req == 2'b11) begin
      winner_c = ~last_gnt;
    end else if (req[1]) begin
      winner_c = PORT_DBG;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-ported data memory between the CPU load/store path
// (port 0) and the debug/loader port (port 1). One access in flight; read
// data returns a fixed MEM_LATENCY cycles after issue.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1   // must be >= 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned CNT_WIDTH = $clog2(MEM_LATENCY + 1);

  logic [1:0]            state, state_d;
  logic [CNT_WIDTH-1:0]  cnt, cnt_d;
  logic                  last_gnt, last_gnt_d;
  logic                  winner, winner_d;
  logic                  win_we, win_we_d;

  logic                  cpu_gnt_d, dbg_gnt_d;
  logic                  cpu_rvalid_d, dbg_rvalid_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_d, dbg_rdata_d;
  logic                  mem_en_d, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic                  busy_d;

  logic                  pick_valid;
  logic                  pick_winner;

  mem_arb_rr_pick u_pick (
    .req      ({dbg_req, cpu_req}),
    .last_gnt (last_gnt),
    .valid_c  (pick_valid),
    .winner_c (pick_winner)
  );

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    last_gnt_d   = last_gnt;
    winner_d     = winner;
    win_we_d     = win_we;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    dbg_rdata_d  = dbg_rdata;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          winner_d   = pick_winner;
          last_gnt_d = pick_winner;
          mem_en_d   = 1'b1;
          state_d    = ST_ISSUE;
          if (pick_winner == PORT_DBG) begin
            win_we_d    = dbg_we;
            mem_we_d    = dbg_we;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
            dbg_gnt_d   = 1'b1;
          end else begin
            win_we_d    = cpu_we;
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            cpu_gnt_d   = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        if (win_we) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_WIDTH'(1);
        end
      end

      ST_WAIT: begin
        if (cnt == CNT_WIDTH'(MEM_LATENCY)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (winner == PORT_DBG) begin
            dbg_rvalid_d = 1'b1;
            dbg_rdata_d  = mem_rdata;
          end else begin
            cpu_rvalid_d = 1'b1;
            cpu_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt + CNT_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, bookkeeping and output registers; reset abandons any access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_gnt   <= PORT_DBG;
      winner     <= PORT_CPU;
      win_we     <= 1'b0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      last_gnt   <= last_gnt_d;
      winner     <= winner_d;
      win_we     <= win_we_d;
      cpu_gnt    <= cpu_gnt_d;
      dbg_gnt    <= dbg_gnt_d;
      cpu_rvalid <= cpu_rvalid_d;
      dbg_rvalid <= dbg_rvalid_d;
      cpu_rdata  <= cpu_rdata_d;
      dbg_rdata  <= dbg_rdata_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two instances (latency 1 and 3) sharing a
// memory model; expected grants/returns are queued with their cycle numbers
// and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Requester payloads shared by both instances; requests are per instance
  logic        cpu_we, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_req1, dbg_req1, cpu_req3, dbg_req3;

  logic        cpu_gnt1, cpu_rvalid1, dbg_gnt1, dbg_rvalid1, m1_en, m1_we, busy1;
  logic [31:0] cpu_rdata1, dbg_rdata1, m1_addr, m1_wdata, m1_rdata;
  logic        cpu_gnt3, cpu_rvalid3, dbg_gnt3, dbg_rvalid3, m3_en, m3_we, busy3;
  logic [31:0] cpu_rdata3, dbg_rdata3, m3_addr, m3_wdata, m3_rdata;

  data_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req1), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
    .dbg_req(dbg_req1), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1), .dbg_rdata(dbg_rdata1),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(busy1)
  );

  data_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req3), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
    .dbg_req(dbg_req3), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt3), .dbg_rvalid(dbg_rvalid3), .dbg_rdata(dbg_rdata3),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata), .busy(busy3)
  );

  // Word memory with fixed read latency per instance
  logic [31:0] mem [0:63];
  logic [31:0] rd1;
  logic [31:0] rd3 [0:2];
  always @(posedge clk) begin
    if (m1_en && m1_we) mem[m1_addr[7:2]] <= m1_wdata;
    if (m3_en && m3_we) mem[m3_addr[7:2]] <= m3_wdata;
    rd1    <= mem[m1_addr[7:2]];
    rd3[0] <= mem[m3_addr[7:2]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign m1_rdata = rd1;
  assign m3_rdata = rd3[2];

  typedef struct {
    int          dut;
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } gexp_t;

  typedef struct {
    int          dut;
    logic        port;
    logic [31:0] data;
    int          cyc;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_g(input int d, input logic p, input logic we,
                        input logic [31:0] a, input logic [31:0] wd, input int c);
    gexp_t g;
    g.dut = d; g.port = p; g.we = we; g.addr = a; g.data = wd; g.cyc = c;
    gq.push_back(g);
  endtask

  task automatic push_r(input int d, input logic p, input logic [31:0] rd, input int c);
    rexp_t r;
    r.dut = d; r.port = p; r.data = rd; r.cyc = c;
    rq.push_back(r);
  endtask

  // Compare one instance's observable events against the queued expectations
  task automatic mon(input int d, input logic cg, input logic dg, input logic cr, input logic dr,
                     input logic [31:0] crd, input logic [31:0] drd, input logic en,
                     input logic we, input logic [31:0] a, input logic [31:0] wd);
    gexp_t g;
    rexp_t r;
    if (cg || dg) begin
      chk("gnt_both", 32'(cg & dg), 32'd0);
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 32'(d), 32'd0);
      end else begin
        g = gq.pop_front();
        chk("gnt_dut", 32'(d), 32'(g.dut));
        chk("gnt_port", 32'(dg), 32'(g.port));
        chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
        chk("gnt_mem_en", 32'(en), 32'd1);
        chk("gnt_mem_we", 32'(we), 32'(g.we));
        chk("gnt_mem_addr", a, g.addr);
        if (g.we) chk("gnt_mem_wdata", wd, g.data);
      end
    end else begin
      chk("mem_en_without_gnt", 32'({en, we}), 32'd0);
    end
    if (cr || dr) begin
      chk("rvalid_both", 32'(cr & dr), 32'd0);
      if (rq.size() == 0) begin
        chk("rvalid_unexpected", 32'(d), 32'd0);
      end else begin
        r = rq.pop_front();
        chk("rv_dut", 32'(d), 32'(r.dut));
        chk("rv_port", 32'(dr), 32'(r.port));
        chk("rv_cycle", 32'(cyc), 32'(r.cyc));
        chk("rv_rdata", dr ? drd : crd, r.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1, cpu_gnt1, dbg_gnt1, cpu_rvalid1, dbg_rvalid1, cpu_rdata1, dbg_rdata1,
        m1_en, m1_we, m1_addr, m1_wdata);
    mon(3, cpu_gnt3, dbg_gnt3, cpu_rvalid3, dbg_rvalid3, cpu_rdata3, dbg_rdata3,
        m3_en, m3_we, m3_addr, m3_wdata);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_ctrl1"}, 32'({cpu_gnt1, cpu_rvalid1, dbg_gnt1, dbg_rvalid1, m1_en, m1_we, busy1}), 32'd0);
    chk({tag, "_cpu_rdata1"}, cpu_rdata1, 32'd0);
    chk({tag, "_dbg_rdata1"}, dbg_rdata1, 32'd0);
    chk({tag, "_mem_addr1"}, m1_addr, 32'd0);
    chk({tag, "_mem_wdata1"}, m1_wdata, 32'd0);
  endtask

  int c;

  initial begin
    rst = 1'b1;
    cpu_req1 = 0; dbg_req1 = 0; cpu_req3 = 0; dbg_req3 = 0;
    cpu_we = 0; dbg_we = 0; cpu_addr = 0; dbg_addr = 0; cpu_wdata = 0; dbg_wdata = 0;
    #1 rst = 1'b0;
    step(2);
    chk_reset1("reset");
    chk("reset_ctrl3", 32'({cpu_gnt3, cpu_rvalid3, dbg_gnt3, dbg_rvalid3, m3_en, m3_we, busy3}), 32'd0);
    rst = 1'b1;
    step(2);

    // CPU write 0x10 <- DEADBEEF, then CPU read it back (latency 1)
    c = cyc;
    cpu_req1 = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    push_g(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, c + 1);
    step(1);
    chk("busy_issue", 32'(busy1), 32'd1);
    step(1);
    c = cyc;
    cpu_we = 0; cpu_addr = 32'h10;
    push_g(1, 1'b0, 1'b0, 32'h10, 32'h0, c + 1);
    push_r(1, 1'b0, 32'hDEADBEEF, c + 3);
    step(2);
    cpu_req1 = 0;
    step(1);

    // Debug write 0x20 <- 12345678
    c = cyc;
    dbg_req1 = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678;
    push_g(1, 1'b1, 1'b1, 32'h20, 32'h12345678, c + 1);
    step(2);
    dbg_req1 = 0;
    step(1);

    // Both ports reading from reset: CPU, DBG, CPU
    rst = 1'b0;
    cpu_req1 = 1; cpu_we = 0; cpu_addr = 32'h10;
    dbg_req1 = 1; dbg_we = 0; dbg_addr = 32'h20;
    step(2);
    rst = 1'b1;
    c = cyc;
    push_g(1, 1'b0, 1'b0, 32'h10, 32'h0, c + 1);
    push_r(1, 1'b0, 32'hDEADBEEF, c + 3);
    push_g(1, 1'b1, 1'b0, 32'h20, 32'h0, c + 4);
    push_r(1, 1'b1, 32'h12345678, c + 6);
    push_g(1, 1'b0, 1'b0, 32'h10, 32'h0, c + 7);
    push_r(1, 1'b0, 32'hDEADBEEF, c + 9);
    step(8);
    cpu_req1 = 0; dbg_req1 = 0;
    step(2);

    // Reset asserted during WAIT of a CPU read: dropped, no rvalid later
    c = cyc;
    cpu_req1 = 1; cpu_we = 0; cpu_addr = 32'h20;
    push_g(1, 1'b0, 1'b0, 32'h20, 32'h0, c + 1);
    step(2);
    cpu_req1 = 0;
    rst = 1'b0;
    #1;
    chk_reset1("midrst");
    step(2);
    rst = 1'b1;
    step(6);
    chk("midrst_rdata_after", cpu_rdata1, 32'd0);
    chk("midrst_busy_after", 32'(busy1), 32'd0);

    // Back-to-back debug writes i -> 4*i, one grant every 2 cycles
    c = cyc;
    dbg_req1 = 1; dbg_we = 1;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 32'(4 * i);
      dbg_wdata = 32'(i);
      push_g(1, 1'b1, 1'b1, 32'(4 * i), 32'(i), c + 2 * i + 1);
      step(2);
    end
    dbg_req1 = 0;
    c = cyc;
    cpu_req1 = 1; cpu_we = 0; cpu_addr = 32'h1C;
    push_g(1, 1'b0, 1'b0, 32'h1C, 32'h0, c + 1);
    push_r(1, 1'b0, 32'd7, c + 3);
    step(2);
    cpu_req1 = 0;
    step(2);

    // Latency 3: debug read, CPU request arrives during WAIT
    c = cyc;
    dbg_req3 = 1; dbg_we = 0; dbg_addr = 32'h20;
    push_g(3, 1'b1, 1'b0, 32'h20, 32'h0, c + 1);
    push_r(3, 1'b1, 32'h12345678, c + 5);
    step(2);
    dbg_req3 = 0;
    step(1);
    cpu_req3 = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hA5A5A5A5;
    push_g(3, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, c + 6);
    chk("busy3_wait", 32'(busy3), 32'd1);
    step(4);
    cpu_req3 = 0;
    step(3);
    c = cyc;
    cpu_req3 = 1; cpu_we = 0; cpu_addr = 32'h40;
    push_g(3, 1'b0, 1'b0, 32'h40, 32'h0, c + 1);
    push_r(3, 1'b0, 32'hA5A5A5A5, c + 5);
    step(2);
    cpu_req3 = 0;
    step(6);
    chk("dbg_rdata3_held", dbg_rdata3, 32'h12345678);

    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("rvalid_queue_drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
